// File: rtl/id_regfile_sb.sv
// id_regfile_sb
// Decode-stage register file with an integrated pending-write scoreboard.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   rd_addr/rd_use  NRD read ports: source address and "real operand" flag
//   rd_data/rd_busy per read port: bypassed data, outstanding-producer flag
//   stall           any used source operand is still busy
//   issue_valid/rd  destination of the instruction leaving decode
//   issue_ready     issue accepted this cycle (no WAW with in-flight producer)
//   wb_valid/addr/data  NWR writeback ports; highest index wins on collisions
//   flush           drops every pending mark (squashed producers)
//   pending_count   registered population count of the pending vector
//
// x0 is hardwired to zero: it is never pending and ignores writes/issues.
module id_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rd_addr       [NRD],
  input  logic            rd_use        [NRD],
  output logic [XLEN-1:0] rd_data       [NRD],
  output logic            rd_busy       [NRD],
  output logic            stall,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wb_valid      [NWR],
  input  logic [AW-1:0]   wb_addr       [NWR],
  input  logic [XLEN-1:0] wb_data       [NWR],
  input  logic            flush,
  output logic [AW:0]     pending_count
);

  // Every address an AW-bit field can encode gets an entry; entries at x0
  // and beyond NREGS read as zero and are never busy.
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] pend_next;
  logic [XLEN-1:0]  cur_data [DEPTH];
  logic             issue_acc;
  logic [AW:0]      count_next;
  logic [AW:0]      count_reg;

  assign issue_ready = ~busy[issue_rd];
  // A flush in the same cycle discards the accepted issue.
  assign issue_acc   = issue_valid & issue_ready & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi > 0 && gi < NREGS) begin : g_live
        logic [XLEN-1:0] data_reg;
        logic            pend_reg;
        logic            hit;
        logic [XLEN-1:0] win;

        // Ascending scan so the highest matching port index wins the data.
        always_comb begin
          hit = 1'b0;
          win = '0;
          for (int p = 0; p < NWR; p++) begin
            if (wb_valid[p] && (wb_addr[p] == AW'(gi))) begin
              hit = 1'b1;
              win = wb_data[p];
            end
          end
        end

        assign cur_data[gi] = hit ? win : data_reg;
        // A writeback landing this cycle already resolves the dependency.
        assign busy[gi]     = pend_reg & ~hit;
        // New producer wins over a same-cycle writeback to the same register.
        assign pend_next[gi] = ~flush &
                               ((issue_acc & (issue_rd == AW'(gi))) |
                                (pend_reg & ~hit));

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            data_reg <= '0;
            pend_reg <= 1'b0;
          end else begin
            if (hit) begin
              data_reg <= win;
            end
            pend_reg <= pend_next[gi];
          end
        end
      end else begin : g_zero
        assign cur_data[gi]  = '0;
        assign busy[gi]      = 1'b0;
        assign pend_next[gi] = 1'b0;
      end
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd
      assign rd_data[gi] = cur_data[rd_addr[gi]];
      assign rd_busy[gi] = busy[rd_addr[gi]];
    end
  endgenerate

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      stall = stall | (rd_use[i] & rd_busy[i]);
    end
  end

  // Count the next-state vector so the registered count matches pend exactly.
  always_comb begin
    count_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_next = count_next + (AW + 1)'(pend_next[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign pending_count = count_reg;

endmodule

// File: tb/tb_id_regfile_sb.sv
module tb_id_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   rd_addr  [NRD];
  logic            rd_use   [NRD];
  logic [XLEN-1:0] rd_data  [NRD];
  logic            rd_busy  [NRD];
  logic            stall;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_ready;
  logic            wb_valid [NWR];
  logic [AW-1:0]   wb_addr  [NWR];
  logic [XLEN-1:0] wb_data  [NWR];
  logic            flush;
  logic [AW:0]     pending_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: architectural values and a set of pending registers.
  logic [XLEN-1:0] mregs [NREGS];
  bit              mpend [NREGS];

  id_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data), .rd_busy(rd_busy),
    .stall(stall),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .pending_count(pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic bit m_wb_hits(input logic [AW-1:0] a);
    for (int p = 0; p < NWR; p++)
      if (wb_valid[p] && wb_addr[p] == a && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] m_data(input logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    if (a == 0) return '0;
    d = mregs[a];
    for (int p = 0; p < NWR; p++)
      if (wb_valid[p] && wb_addr[p] == a) d = wb_data[p];
    return d;
  endfunction

  function automatic bit m_busy(input logic [AW-1:0] a);
    return (a != 0) && mpend[a] && !m_wb_hits(a);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < NREGS; r++) c += int'(mpend[r]);
    return c;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      mregs[r] = '0;
      mpend[r] = 1'b0;
    end
  endtask

  // Advance model with the currently driven inputs, then the DUT clock edge.
  task automatic tick();
    bit acc;
    bit hits [NREGS];
    acc = issue_valid && !m_busy(issue_rd) && !flush && issue_rd != 0;
    for (int r = 0; r < NREGS; r++) hits[r] = m_wb_hits(AW'(r));
    for (int p = 0; p < NWR; p++)
      if (wb_valid[p] && wb_addr[p] != 0) mregs[wb_addr[p]] = wb_data[p];
    for (int r = 0; r < NREGS; r++) if (hits[r]) mpend[r] = 1'b0;
    if (flush) for (int r = 0; r < NREGS; r++) mpend[r] = 1'b0;
    if (acc) mpend[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NRD; i++) begin rd_addr[i] = '0; rd_use[i] = 1'b0; end
    for (int p = 0; p < NWR; p++) begin wb_valid[p] = 1'b0; wb_addr[p] = '0; wb_data[p] = '0; end
    issue_valid = 1'b0;
    issue_rd    = '0;
    flush       = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    rd_use[0] = 1'b1; rd_use[1] = 1'b1;
    issue_rd = AW'($urandom_range(1, NREGS - 1));
    #1;
    tests_run++;
    if (pending_count !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", pending_count); end
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tests_run++;
    if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", issue_ready); end
    for (int r = 0; r < NREGS; r++) begin
      rd_addr[0] = AW'(r);
      #1;
      tests_run++;
      if (rd_data[0] !== '0 || rd_busy[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_read x%0d: data=%h busy=%b expected 0/0", r, rd_data[0], rd_busy[0]);
      end
    end
    idle();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_bypass();
    idle();
    wb_valid[0] = 1'b1; wb_addr[0] = 5'd5; wb_data[0] = 32'h1234;
    rd_addr[0] = 5'd5;
    #1;
    tests_run++;
    if (rd_data[0] !== 32'h1234) begin tests_failed++; $display("FAIL bypass_x5: got %h expected %h", rd_data[0], 32'h1234); end
    tick();
    idle();
    rd_addr[0] = 5'd5;
    #1;
    tests_run++;
    if (rd_data[0] !== 32'h1234) begin tests_failed++; $display("FAIL stored_x5: got %h expected %h", rd_data[0], 32'h1234); end
    wb_valid[0] = 1'b1; wb_addr[0] = 5'd0; wb_data[0] = 32'hFFFF;
    rd_addr[0] = 5'd0;
    #1;
    tests_run++;
    if (rd_data[0] !== '0) begin tests_failed++; $display("FAIL x0_bypass: got %h expected 0", rd_data[0]); end
    tick();
    idle();
    #1;
    tests_run++;
    if (rd_data[0] !== '0) begin tests_failed++; $display("FAIL x0_stored: got %h expected 0", rd_data[0]); end
  endtask

  task automatic test_issue_wb();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL issue_x7_ready: got %b expected 1", issue_ready); end
    tick();
    idle();
    rd_addr[0] = 5'd7; rd_use[0] = 1'b1;
    #1;
    tests_run++;
    if (rd_busy[0] !== 1'b1 || stall !== 1'b1) begin tests_failed++; $display("FAIL pending_x7: busy=%b stall=%b expected 1/1", rd_busy[0], stall); end
    tests_run++;
    if (pending_count !== 6'd1) begin tests_failed++; $display("FAIL count_x7: got %0d expected 1", pending_count); end
    wb_valid[1] = 1'b1; wb_addr[1] = 5'd7; wb_data[1] = 32'hAA;
    #1;
    tests_run++;
    if (rd_busy[0] !== 1'b0 || stall !== 1'b0 || rd_data[0] !== 32'hAA) begin
      tests_failed++;
      $display("FAIL wb_x7: busy=%b stall=%b data=%h expected 0/0/aa", rd_busy[0], stall, rd_data[0]);
    end
    tick();
    idle();
    tests_run++;
    if (pending_count !== 6'd0) begin tests_failed++; $display("FAIL count_after_wb: got %0d expected 0", pending_count); end
  endtask

  task automatic test_dual_port();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    idle();
    wb_valid[0] = 1'b1; wb_addr[0] = 5'd3; wb_data[0] = 32'h11;
    wb_valid[1] = 1'b1; wb_addr[1] = 5'd3; wb_data[1] = 32'h22;
    rd_addr[1] = 5'd3; rd_use[1] = 1'b1;
    #1;
    tests_run++;
    if (rd_data[1] !== 32'h22 || rd_busy[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL dual_bypass: data=%h busy=%b expected 22/0", rd_data[1], rd_busy[1]);
    end
    tick();
    idle();
    rd_addr[1] = 5'd3;
    #1;
    tests_run++;
    if (rd_data[1] !== 32'h22) begin tests_failed++; $display("FAIL dual_stored: got %h expected 22", rd_data[1]); end
    tests_run++;
    if (pending_count !== 6'd0) begin tests_failed++; $display("FAIL dual_count: got %0d expected 0", pending_count); end
  endtask

  task automatic test_waw();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL waw_refused: got %b expected 0", issue_ready); end
    tick();
    tests_run++;
    if (pending_count !== 6'd1) begin tests_failed++; $display("FAIL waw_count: got %0d expected 1", pending_count); end
    wb_valid[0] = 1'b1; wb_addr[0] = 5'd9; wb_data[0] = 32'h55;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL waw_with_wb_ready: got %b expected 1", issue_ready); end
    tick();
    idle();
    rd_addr[0] = 5'd9; rd_use[0] = 1'b1;
    #1;
    tests_run++;
    if (rd_busy[0] !== 1'b1 || rd_data[0] !== 32'h55 || pending_count !== 6'd1) begin
      tests_failed++;
      $display("FAIL waw_reissue: busy=%b data=%h count=%0d expected 1/55/1", rd_busy[0], rd_data[0], pending_count);
    end
    idle();
    wb_valid[0] = 1'b1; wb_addr[0] = 5'd9; wb_data[0] = 32'h56;
    tick();
    idle();
  endtask

  task automatic test_flush();
    for (int r = 4; r <= 6; r++) begin
      idle();
      issue_valid = 1'b1; issue_rd = AW'(r);
      tick();
    end
    idle();
    tests_run++;
    if (pending_count !== 6'd3) begin tests_failed++; $display("FAIL flush_pre_count: got %0d expected 3", pending_count); end
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd8;
    tick();
    idle();
    tests_run++;
    if (pending_count !== 6'd0) begin tests_failed++; $display("FAIL flush_count: got %0d expected 0", pending_count); end
    rd_addr[0] = 5'd4; rd_addr[1] = 5'd8;
    #1;
    tests_run++;
    if (rd_busy[0] !== 1'b0 || rd_busy[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_busy: x4=%b x8=%b expected 0/0", rd_busy[0], rd_busy[1]);
    end
  endtask

  task automatic test_random();
    bit exp_stall;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NRD; i++) begin
        rd_addr[i] = AW'($urandom_range(0, NREGS - 1));
        rd_use[i]  = 1'($urandom_range(0, 1));
      end
      for (int p = 0; p < NWR; p++) begin
        wb_valid[p] = ($urandom_range(0, 9) < 4);
        wb_addr[p]  = AW'($urandom_range(0, NREGS - 1));
        wb_data[p]  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = AW'($urandom_range(0, NREGS - 1));
      flush       = ($urandom_range(0, 24) == 0);
      #1;
      exp_stall = 1'b0;
      for (int i = 0; i < NRD; i++) begin
        tests_run++;
        if (rd_data[i] !== m_data(rd_addr[i]) || rd_busy[i] !== m_busy(rd_addr[i])) begin
          tests_failed++;
          $display("FAIL rand_read c%0d p%0d x%0d: data=%h busy=%b expected %h/%b",
                   cyc, i, rd_addr[i], rd_data[i], rd_busy[i], m_data(rd_addr[i]), m_busy(rd_addr[i]));
        end
        exp_stall = exp_stall | (rd_use[i] && m_busy(rd_addr[i]));
      end
      tests_run++;
      if (stall !== exp_stall || issue_ready !== !m_busy(issue_rd)) begin
        tests_failed++;
        $display("FAIL rand_ctrl c%0d: stall=%b ready=%b expected %b/%b",
                 cyc, stall, issue_ready, exp_stall, !m_busy(issue_rd));
      end
      tick();
      tests_run++;
      if (int'(pending_count) != m_count()) begin
        tests_failed++;
        $display("FAIL rand_count c%0d: got %0d expected %0d", cyc, pending_count, m_count());
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    flush = 1'b1;
    tick();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    idle();
    wb_valid[0] = 1'b1; wb_addr[0] = 5'd11; wb_data[0] = 32'h77;
    tick();
    idle();
    rd_addr[0] = 5'd11; rd_addr[1] = 5'd10; rd_use[1] = 1'b1;
    issue_rd = 5'd10;
    #1;
    tests_run++;
    if (stall !== 1'b1 || rd_data[0] !== 32'h77) begin
      tests_failed++;
      $display("FAIL pre_reset: stall=%b data=%h expected 1/77", stall, rd_data[0]);
    end
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (pending_count !== '0 || stall !== 1'b0 || issue_ready !== 1'b1 ||
        rd_busy[1] !== 1'b0 || rd_data[0] !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: count=%0d stall=%b ready=%b busy=%b data=%h expected 0/0/1/0/0",
               pending_count, stall, issue_ready, rd_busy[1], rd_data[0]);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int r = 0; r < NREGS; r++) begin
      rd_addr[0] = AW'(r);
      #1;
      tests_run++;
      if (rd_data[0] !== '0) begin tests_failed++; $display("FAIL post_reset x%0d: got %h expected 0", r, rd_data[0]); end
    end
    tests_run++;
    if (pending_count !== '0) begin tests_failed++; $display("FAIL post_reset_count: got %0d expected 0", pending_count); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_issue_wb();
    test_dual_port();
    test_waw();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
